calc_run_ctrl: RTL and testbench
================================

Name: calc_run_ctrl

Overview:
- Synthesizable run controller for the calc core. It replaces fixed-delay simulation runs with a deterministic start/halt sequence.
- Holds the core in reset for a configurable number of cycles, then enables it and monitors the fetched PC and instruction every cycle.
- Stops the core on an exit syscall, on an end-of-program PC, or on cycle-budget exhaustion, and reports which one occurred.
- Sits between the top-level bench/board logic and the calc core's clock-enable and reset inputs.

Parameters:
ADDR_W, 32, width of the PC and end_pc
CNT_W, 16, width of the cycle counter
MAX_CYCLES, 1000, cycle budget before timeout; must be < 2^CNT_W
RST_CYCLES, 2, cycles the core is held in reset after start; must be >= 1
SYSCALL_WORD, 32'h0000000C, instruction encoding treated as program exit
TRACE_DEPTH, 8, PC history depth; power of 2; used only with CALC_RUN_TRACE_EN

Ports:
clk  in  1  single system clock; all logic on posedge
reset  in  1  synchronous, active-low; sampled on posedge clk; 0 = reset
start  in  1  one-cycle pulse requesting a run
end_pc  in  ADDR_W  PC value that marks the end of the program
pc_in  in  ADDR_W  current PC from the core
instr_in  in  32  instruction currently fetched at pc_in
core_en  out  1  clock enable to the core
core_rst_n  out  1  active-low reset to the core
busy  out  1  high from the start acceptance through the last RUN cycle
done  out  1  high in DONE; held until the next accepted start or reset
status  out  2  halt cause: 0 none, 1 syscall, 2 end_pc, 3 timeout
cycle_count  out  CNT_W  number of RUN cycles executed
halt_pc  out  ADDR_W  pc_in captured on the halt cycle
trace_idx  in  log2(TRACE_DEPTH)  read index; 0 = newest (feature only)
trace_pc  out  ADDR_W  PC history entry selected by trace_idx (feature only)

Behaviour:
- Reset: when reset=0 at posedge, the block returns to IDLE from any state, including mid-run.
  - Reset values: core_en=0, core_rst_n=0, busy=0, done=0, status=0, cycle_count=0, halt_pc=0.
  - A reset during a run must produce no halt status.
- States: IDLE, CORE_RST, RUN, DONE; 2-bit encoding.
- IDLE:
  - core_en=0, core_rst_n=0.
  - start=1 -> CORE_RST. On that edge: rst counter loads RST_CYCLES-1, cycle_count and status clear, done clears, busy sets.
- CORE_RST:
  - core_rst_n=0, core_en=0.
  - Stays for exactly RST_CYCLES cycles, then -> RUN.
- RUN:
  - core_rst_n=1, core_en=1. cycle_count increments by 1 each RUN cycle.
  - Each cycle, evaluate pc_in/instr_in in this priority order:
    - instr_in==SYSCALL_WORD -> status 1
    - pc_in==end_pc -> status 2
    - cycle_count==MAX_CYCLES-1 -> status 3
  - On any hit, at that edge: capture halt_pc=pc_in, go to DONE, core_en drops next cycle.
  - The halting cycle is counted, so a timeout leaves cycle_count=MAX_CYCLES.
  - A halt condition present on the first RUN cycle is honoured, giving cycle_count=1.
- DONE:
  - core_en=0, core_rst_n=1 so core state stays inspectable. busy=0, done=1.
  - start=1 -> CORE_RST; this is a restart and clears status and cycle_count.
- start asserted in CORE_RST or RUN is ignored.
- Outputs are registered; there are no combinational paths from inputs to outputs except trace_pc's read mux.
- cycle_count saturates and never wraps, which is guaranteed by the MAX_CYCLES constraint.

Optional Feature:
- Macro: CALC_RUN_TRACE_EN.
- When defined:
  - Circular buffer of TRACE_DEPTH x ADDR_W, written with pc_in on every RUN cycle, including the halt cycle.
  - Write pointer wraps modulo TRACE_DEPTH and clears on reset and on start.
  - trace_pc = entry at (wptr-1-trace_idx) mod TRACE_DEPTH.
  - Unwritten entries read 0 (valid bits clear on start).
- When not defined: buffer is absent, trace_idx is ignored, trace_pc is tied to 0.

Decomposition:
- Package calc_run_pkg holds:
  - state enum constants: S_IDLE=0, S_CORE_RST=1, S_RUN=2, S_DONE=3
  - status constants: ST_NONE=0, ST_SYSCALL=1, ST_ENDPC=2, ST_TIMEOUT=3
  - default SYSCALL_WORD
- One sub-module: calc_pc_trace_buf, the circular PC buffer, instantiated only under CALC_RUN_TRACE_EN.

Test Plan:
- RST_CYCLES=2, end_pc=0x10, pc_in steps by 4 from 0 each enabled cycle; pulse start -> core_rst_n low for 2 cycles; halt with status=2, halt_pc=0x10, cycle_count=5, done=1.
- instr_in=0x0000000C on pc=0x8 with end_pc=0x8 simultaneously -> status=1 (syscall wins), halt_pc=0x8.
- MAX_CYCLES=20, no halt conditions -> status=3, cycle_count=20, core_en low from the next cycle.
- reset=0 for one cycle during RUN at cycle 3 -> IDLE, all outputs at reset values, status=0; a subsequent start runs cleanly.
- In DONE, pulse start -> status/cycle_count clear, CORE_RST re-entered. A start pulse mid-RUN has no effect.
- With CALC_RUN_TRACE_EN, TRACE_DEPTH=8, run of 11 PCs 0x0..0x28 -> trace_idx 0 reads 0x28, trace_idx 7 reads 0xC (wrap verified).

Source files
------------

// File: rtl/calc_run_pkg.sv
// rtl/calc_run_pkg.sv - shared state, status and encoding constants for the calc run controller
package calc_run_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CORE_RST = 2'd1,
        S_RUN      = 2'd2,
        S_DONE     = 2'd3
    } run_state_t;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_SYSCALL = 2'd1;
    localparam logic [1:0] ST_ENDPC   = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam logic [31:0] DEF_SYSCALL_WORD = 32'h0000_000C;

endpackage

// File: rtl/calc_pc_trace_buf.sv
// rtl/calc_pc_trace_buf.sv - circular PC history buffer, newest entry at read index 0
module calc_pc_trace_buf #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [ADDR_W-1:0] o_rd_data
);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [IDX_W-1:0]  r_wptr;
    logic [IDX_W-1:0]  w_rd_ptr;

    // write pointer and valid bits; cleared on reset and at every run start
    always_ff @(posedge clk) begin
        if (!resetn || i_clr) begin
            r_wptr  <= '0;
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[r_wptr] <= 1'b1;
            r_wptr          <= r_wptr + 1'b1;
        end
    end

    // storage array; contents are masked by r_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    // depth is a power of two, so the pointer arithmetic wraps naturally
    assign w_rd_ptr  = r_wptr - IDX_W'(1) - i_rd_idx;
    assign o_rd_data = r_valid[w_rd_ptr] ? r_mem[w_rd_ptr] : '0;

endmodule

// File: rtl/calc_run_ctrl.sv
// rtl/calc_run_ctrl.sv - start/halt run controller for the calc core (optional PC trace: CALC_RUN_TRACE_EN)
module calc_run_ctrl
    import calc_run_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          CNT_W        = 16,
    parameter int          MAX_CYCLES   = 1000,
    parameter int          RST_CYCLES   = 2,
    parameter logic [31:0] SYSCALL_WORD = DEF_SYSCALL_WORD,
    parameter int          TRACE_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              end_pc,
    input  logic [ADDR_W-1:0]              pc_in,
    input  logic [31:0]                    instr_in,
    output logic                           core_en,
    output logic                           core_rst_n,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     status,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [ADDR_W-1:0]              halt_pc,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [ADDR_W-1:0]              trace_pc
);

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    run_state_t        r_state;
    run_state_t        w_next;
    logic [CNT_W-1:0]  r_rst_cnt;
    logic              r_core_en;
    logic              r_core_rst_n;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_status;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [ADDR_W-1:0] r_halt_pc;
    logic              w_start_acc;
    logic              w_hit;
    logic [1:0]        w_hit_status;

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and halt detection; syscall beats end_pc beats timeout
    always_comb begin
        w_next       = r_state;
        w_start_acc  = 1'b0;
        w_hit        = 1'b0;
        w_hit_status = ST_NONE;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next      = S_CORE_RST;
                    w_start_acc = 1'b1;
                end
            end
            S_CORE_RST: begin
                if (r_rst_cnt == '0) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (instr_in == SYSCALL_WORD) begin
                    w_hit        = 1'b1;
                    w_hit_status = ST_SYSCALL;
                end else if (pc_in == end_pc) begin
                    w_hit        = 1'b1;
                    w_hit_status = ST_ENDPC;
                end else if (r_cycle_count == CNT_LAST) begin
                    w_hit        = 1'b1;
                    w_hit_status = ST_TIMEOUT;
                end
                if (w_hit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next      = S_CORE_RST;
                    w_start_acc = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // registered outputs decoded from the upcoming state, plus run bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rst_cnt     <= '0;
            r_core_en     <= 1'b0;
            r_core_rst_n  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_status      <= ST_NONE;
            r_cycle_count <= '0;
            r_halt_pc     <= '0;
        end else begin
            r_core_en    <= (w_next == S_RUN);
            r_core_rst_n <= (w_next == S_RUN) || (w_next == S_DONE);
            r_busy       <= (w_next == S_CORE_RST) || (w_next == S_RUN);
            r_done       <= (w_next == S_DONE);
            if (w_start_acc) begin
                r_rst_cnt     <= RST_LOAD;
                r_cycle_count <= '0;
                r_status      <= ST_NONE;
            end else if (r_state == S_CORE_RST) begin
                if (r_rst_cnt != '0) begin
                    r_rst_cnt <= r_rst_cnt - 1'b1;
                end
            end else if (r_state == S_RUN) begin
                if (r_cycle_count != '1) begin
                    r_cycle_count <= r_cycle_count + 1'b1;
                end
                if (w_hit) begin
                    r_status  <= w_hit_status;
                    r_halt_pc <= pc_in;
                end
            end
        end
    end

    assign core_en     = r_core_en;
    assign core_rst_n  = r_core_rst_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign status      = r_status;
    assign cycle_count = r_cycle_count;
    assign halt_pc     = r_halt_pc;

`ifdef CALC_RUN_TRACE_EN
    calc_pc_trace_buf #(
        .ADDR_W (ADDR_W),
        .DEPTH  (TRACE_DEPTH),
        .IDX_W  ($clog2(TRACE_DEPTH))
    ) u_trace (
        .clk       (clk),
        .resetn    (reset),
        .i_clr     (w_start_acc),
        .i_wr_en   (r_state == S_RUN),
        .i_wr_data (pc_in),
        .i_rd_idx  (trace_idx),
        .o_rd_data (trace_pc)
    );
`else
    logic w_trace_unused;
    assign w_trace_unused = ^trace_idx;
    assign trace_pc       = '0;
`endif

endmodule

// File: tb/tb_calc_run_ctrl.sv
// tb/tb_calc_run_ctrl.sv - directed self-checking bench for calc_run_ctrl
module tb_calc_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] end_pc;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic        core_en;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [15:0] cycle_count;
    logic [31:0] halt_pc;
    logic [2:0]  trace_idx;
    logic [31:0] trace_pc;

    logic        sys_en;
    logic [31:0] sys_pc;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    calc_run_ctrl #(
        .ADDR_W       (32),
        .CNT_W        (16),
        .MAX_CYCLES   (20),
        .RST_CYCLES   (2),
        .SYSCALL_WORD (32'h0000_000C),
        .TRACE_DEPTH  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .end_pc      (end_pc),
        .pc_in       (pc),
        .instr_in    (instr_in),
        .core_en     (core_en),
        .core_rst_n  (core_rst_n),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .cycle_count (cycle_count),
        .halt_pc     (halt_pc),
        .trace_idx   (trace_idx),
        .trace_pc    (trace_pc)
    );

    // core model: PC steps by 4 on each enabled cycle, zero while in reset
    always @(posedge clk) begin
        if (!core_rst_n) pc <= 32'h0;
        else if (core_en) pc <= pc + 32'h4;
    end

    assign instr_in = (sys_en && pc == sys_pc) ? 32'h0000_000C : 32'h0000_0013;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output logic en_before);
        int n;
        n = 0;
        en_before = 1'b0;
        while (done !== 1'b1 && n < 300) begin
            en_before = core_en;
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        end_pc = 32'h10;
        sys_en = 1'b0;
        sys_pc = 32'h0;
        trace_idx = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({core_en, core_rst_n, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: en/rstn/busy/done=%b required 0000", {core_en, core_rst_n, busy, done});
        end
        checks++;
        if (status !== 2'd0 || cycle_count !== 16'd0 || halt_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: status=%0d count=%0d halt_pc=%h required 0/0/0", status, cycle_count, halt_pc);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_endpc();
        int n;
        logic en_b;
        end_pc = 32'h10;
        pulse_start();
        n = 0;
        while (busy === 1'b1 && core_rst_n === 1'b0 && n < 10) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL endpc_rst_len: core_rst_n low %0d cycles, required 2", n);
        end
        wait_done(en_b);
        checks++;
        if (status !== 2'd2 || halt_pc !== 32'h10 || cycle_count !== 16'd5) begin
            errors++;
            $display("FAIL endpc_halt: status=%0d halt_pc=%h count=%0d required 2/10/5", status, halt_pc, cycle_count);
        end
        checks++;
        if ({core_en, core_rst_n, busy, done} !== 4'b0101) begin
            errors++;
            $display("FAIL endpc_done_ctrl: en/rstn/busy/done=%b required 0101", {core_en, core_rst_n, busy, done});
        end
    endtask

    task automatic test_syscall();
        logic en_b;
        end_pc = 32'h8;
        sys_en = 1'b1;
        sys_pc = 32'h8;
        pulse_start();
        wait_done(en_b);
        checks++;
        if (status !== 2'd1 || halt_pc !== 32'h8 || cycle_count !== 16'd3) begin
            errors++;
            $display("FAIL syscall_prio: status=%0d halt_pc=%h count=%0d required 1/8/3", status, halt_pc, cycle_count);
        end
        sys_en = 1'b0;
    endtask

    task automatic test_timeout();
        logic en_b;
        end_pc = 32'hFFFF_FFF0;
        pulse_start();
        wait_done(en_b);
        checks++;
        if (status !== 2'd3 || cycle_count !== 16'd20 || halt_pc !== 32'h4C) begin
            errors++;
            $display("FAIL timeout_halt: status=%0d count=%0d halt_pc=%h required 3/20/4c", status, cycle_count, halt_pc);
        end
        checks++;
        if (en_b !== 1'b1 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_en_drop: en before=%b en now=%b required 1/0", en_b, core_en);
        end
    endtask

    task automatic test_restart();
        int n;
        logic en_b;
        end_pc = 32'h10;
        pulse_start();
        checks++;
        if (status !== 2'd0 || cycle_count !== 16'd0 || done !== 1'b0 || busy !== 1'b1 || core_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: status=%0d count=%0d done=%b busy=%b rstn=%b required 0/0/0/1/0",
                     status, cycle_count, done, busy, core_rst_n);
        end
        n = 0;
        while (core_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (core_en !== 1'b1 || core_rst_n !== 1'b1 || cycle_count !== 16'd3) begin
            errors++;
            $display("FAIL midrun_start: en=%b rstn=%b count=%0d required 1/1/3", core_en, core_rst_n, cycle_count);
        end
        wait_done(en_b);
        checks++;
        if (status !== 2'd2 || cycle_count !== 16'd5) begin
            errors++;
            $display("FAIL midrun_finish: status=%0d count=%0d required 2/5", status, cycle_count);
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        logic en_b;
        end_pc = 32'hFFFF_FFF0;
        pulse_start();
        n = 0;
        while (core_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({core_en, core_rst_n, busy, done} !== 4'b0000 || status !== 2'd0 ||
            cycle_count !== 16'd0 || halt_pc !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset: en/rstn/busy/done=%b status=%0d count=%0d halt_pc=%h required 0000/0/0/0",
                     {core_en, core_rst_n, busy, done}, status, cycle_count, halt_pc);
        end
        end_pc = 32'h10;
        pulse_start();
        wait_done(en_b);
        checks++;
        if (status !== 2'd2 || cycle_count !== 16'd5 || halt_pc !== 32'h10) begin
            errors++;
            $display("FAIL post_reset_run: status=%0d count=%0d halt_pc=%h required 2/5/10", status, cycle_count, halt_pc);
        end
    endtask

    task automatic test_trace();
        logic en_b;
        end_pc = 32'h28;
        trace_idx = 3'd0;
        pulse_start();
        checks++;
        if (trace_pc !== 32'h0) begin
            errors++;
            $display("FAIL trace_cleared: trace_pc=%h required 0", trace_pc);
        end
        wait_done(en_b);
        checks++;
        if (cycle_count !== 16'd11 || halt_pc !== 32'h28) begin
            errors++;
            $display("FAIL trace_run: count=%0d halt_pc=%h required 11/28", cycle_count, halt_pc);
        end
`ifdef CALC_RUN_TRACE_EN
        trace_idx = 3'd0;
        #1;
        checks++;
        if (trace_pc !== 32'h28) begin
            errors++;
            $display("FAIL trace_idx0: trace_pc=%h required 28", trace_pc);
        end
        trace_idx = 3'd1;
        #1;
        checks++;
        if (trace_pc !== 32'h24) begin
            errors++;
            $display("FAIL trace_idx1: trace_pc=%h required 24", trace_pc);
        end
        trace_idx = 3'd7;
        #1;
        checks++;
        if (trace_pc !== 32'hC) begin
            errors++;
            $display("FAIL trace_idx7: trace_pc=%h required c", trace_pc);
        end
`else
        trace_idx = 3'd5;
        #1;
        checks++;
        if (trace_pc !== 32'h0) begin
            errors++;
            $display("FAIL trace_tied: trace_pc=%h required 0", trace_pc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_endpc();
        test_syscall();
        test_timeout();
        test_restart();
        test_reset_midrun();
        test_trace();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
